pop_count_pipe: RTL
===================

# pop_count_pipe

Parametrised, pipelined population counter, successor to the 16-bit combinational counter. It counts set bits of a WIDTH-bit word using a registered pairwise-adder tree, with one tree level per stage. It adds a valid/ready stream interface with backpressure. It also has a frame-accumulate mode that sums counts across a multi-word frame into a saturating ACC_WIDTH-bit total.

## Interface
- WIDTH, 16, input word width; power of two, 2..256
- ACC_WIDTH, 16, output/accumulator width; must be >= CW, where CW = $clog2(WIDTH+1)
- Derived: LEVELS = $clog2(WIDTH); CW = $clog2(WIDTH+1)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the word this cycle
- bin  input  WIDTH  word to count
- in_last  input  1  last word of a frame; used only when acc_mode=1
- acc_mode  input  1  0 = per-word count, 1 = accumulate across the frame; sampled per word
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out  output  ACC_WIDTH  count or frame total, zero-extended
- out_sat  output  1  frame total saturated; always 0 in per-word results

## Operation
- Global enable: en = in_ready = !out_valid || out_ready. All pipeline and accumulator registers update only when en=1, so the whole pipeline stalls together.
- Accept: a word is accepted when in_valid && in_ready. Its acc_mode and in_last are captured with it and travel alongside.
- Tree stage k (1..LEVELS):
  - Input is WIDTH/2^(k-1) fields; output is WIDTH/2^k fields of k+1 bits, each the sum of an adjacent field pair.
  - Stage 1 pairs raw bits.
  - Each stage holds a valid bit. Bubbles (valid=0) propagate when en=1.
  - The final stage yields the count, 0..WIDTH, in CW bits.
- Output stage (state IDLE/ACCUM, held as acc != 0 or sticky != 0; acc register ACC_WIDTH bits plus a sticky saturation bit):
  - Tail element with valid=0 and en=1: out_valid <= 0; acc, sticky and out unchanged.
  - Mode 0: out <= count, out_sat <= 0, out_valid <= 1. acc and sticky are untouched, so a mode-0 word interleaved into a frame does not disturb it.
  - Mode 1: sum = acc + count. If sum > 2^ACC_WIDTH-1, then sum = 2^ACC_WIDTH-1 and sticky is set.
    - in_last=0: acc <= sum, sticky updated, out_valid <= 0.
    - in_last=1: out <= sum, out_sat <= sticky (including this word's overflow), out_valid <= 1, acc <= 0, sticky <= 0. State returns to IDLE.
  - A mode-1 single-word frame (in_last=1 on its first word) outputs that word's count directly.
- out and out_sat hold stable while out_valid && !out_ready.
- Reset, asynchronous, any time:
  - All stage valids clear; out_valid=0, out=0, out_sat=0, acc=0, sticky=0.
  - in_ready=1 whenever out_valid=0.
  - In-flight words and any partial frame are discarded and never emitted.

## Timing
- Latency: a word accepted at edge N produces out_valid=1 after edge N+LEVELS+1, assuming no stall. For WIDTH=16 that is 5 cycles.
- Throughput: one word per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, in_ready=0 in the same cycle (combinational). Pipeline contents are frozen and no word is lost or duplicated.
- in_ready depends combinationally only on out_valid and out_ready, never on in_valid.
- Frame mode: exactly one result per frame, at latency LEVELS+1 after the in_last word is accepted. Non-last mode-1 words produce no out_valid pulse.

## Test plan
- Single word, WIDTH=16, mode 0, bin=16'hFFFF -> out=16, out_sat=0, out_valid high exactly 5 cycles after accept.
- Back-to-back mode 0 words 16'h0000, 16'h5555, 16'h8001, out_ready=1 -> out_valid on 3 consecutive cycles with out = 0, 8, 2.
- Backpressure: stream 16'h00FF, 16'h0F0F, 16'h0001 and hold out_ready=0 for 3 cycles at the first result -> in_ready=0 during the hold, out stays 8, and results 8, 8, 1 appear in order with none lost.
- Frame, mode 1: 16'h00FF, 16'h0F0F, then 16'hFFFF with in_last=1 -> single result out=32, out_sat=0; no out_valid for the first two words.
- Saturation, ACC_WIDTH=5: frame 16'hFFFF, 16'hFFFF with in_last=1 -> out=31, out_sat=1. The next frame, 16'h0003 with in_last=1 -> out=2, out_sat=0 (sticky cleared).
- Reset mid-frame: two mode-1 words accepted, assert rst for 1 cycle -> all outputs 0 immediately. A following frame 16'h0001 with in_last=1 -> out=1, with no carry-over from the discarded words.

Source files
------------

// File: rtl/pop_count_pipe.sv
// Pipelined population counter: input register, one registered pairwise-adder level per stage,
// then an output stage that either passes the count through or sums it into a saturating frame total.
module pop_count_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     bin,
  input  logic                 in_last,
  input  logic                 acc_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 out_sat
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int CW     = $clog2(WIDTH + 1);

  logic               en;
  logic [WIDTH-1:0]   bin_q;
  logic [CW-1:0]      node [1:WIDTH-1];
  logic [LEVELS:0]    v_pipe;
  logic [LEVELS:0]    m_pipe;
  logic [LEVELS:0]    l_pipe;
  logic [CW-1:0]      count;
  logic               tail_valid;
  logic               tail_mode;
  logic               tail_last;

  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic [ACC_WIDTH:0]   sum_raw;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sum_sat;

  // One shared enable freezes the whole pipeline while the result is held.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Heap-indexed adder tree: node i sums children 2i and 2i+1; indices >= WIDTH are raw bits.
  // Level k occupies nodes WIDTH>>k .. (WIDTH>>(k-1))-1, so node[1] is the final count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      for (int i = 1; i < WIDTH; i++) node[i] <= '0;
    end else if (en) begin
      bin_q <= bin;
      for (int i = WIDTH / 2; i < WIDTH; i++)
        node[i] <= CW'(bin_q[2*i-WIDTH]) + CW'(bin_q[2*i+1-WIDTH]);
      for (int i = 1; i < WIDTH / 2; i++)
        node[i] <= node[2*i] + node[2*i+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe <= '0;
      m_pipe <= '0;
      l_pipe <= '0;
    end else if (en) begin
      v_pipe[0] <= in_valid;
      m_pipe[0] <= acc_mode;
      l_pipe[0] <= in_last;
      for (int k = 1; k <= LEVELS; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        m_pipe[k] <= m_pipe[k-1];
        l_pipe[k] <= l_pipe[k-1];
      end
    end
  end

  assign count      = node[1];
  assign tail_valid = v_pipe[LEVELS];
  assign tail_mode  = m_pipe[LEVELS];
  assign tail_last  = l_pipe[LEVELS];

  assign sum_raw = {1'b0, acc} + (ACC_WIDTH+1)'(count);
  assign sum_ovf = sum_raw[ACC_WIDTH];
  assign sum_sat = sum_ovf ? '1 : sum_raw[ACC_WIDTH-1:0];

  // A frame is in progress whenever acc or sticky is nonzero; last word returns both to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      sticky    <= 1'b0;
    end else if (en) begin
      if (!tail_valid) begin
        out_valid <= 1'b0;
      end else if (!tail_mode) begin
        out       <= ACC_WIDTH'(count);
        out_sat   <= 1'b0;
        out_valid <= 1'b1;
      end else if (tail_last) begin
        out       <= sum_sat;
        out_sat   <= sticky || sum_ovf;
        out_valid <= 1'b1;
        acc       <= '0;
        sticky    <= 1'b0;
      end else begin
        acc       <= sum_sat;
        sticky    <= sticky || sum_ovf;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
